piso_stream: RTL and testbench

- Parametrised single-clock parallel-in/serial-out converter with an input word FIFO.
- Generalises the earlier PISO:
  - configurable serial lane count (LANES bits per beat);
  - runtime MSB/LSB-first order;
  - last-beat marker and FIFO level output;
  - zero-bubble back-to-back words.
- Sits between a parallel producer (valid/ready) and a narrow serial link or consumer (valid/ready).

---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_sync_fifo.sv | 50 +++++
 rtl/piso_stream.sv | 117 +++++++++++
 tb/tb_piso_stream.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_stream shared types and helpers.
// Beat-count helper, FSM state encoding and bit-order encoding.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

endpackage

// File: rtl/piso_sync_fifo.sv
// piso_stream input word FIFO: single clock, WIDTH x DEPTH.
// Extra-bit pointers give full/empty/level without a separate counter.
module piso_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign do_wr = push && !full;
    assign do_rd = pop && !empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push / pop.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/piso_stream.sv
// piso_stream: FIFO-fed parallel-in/serial-out converter, LANES bits/beat.
// Optional PISO_STREAM_PARITY_EN adds par_o, even parity of current word.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         d_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     msb_first_i,
    output logic [LANES-1:0]         d_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   level_o
`ifdef PISO_STREAM_PARITY_EN
    ,
    output logic                     par_o
`endif
);

    localparam int NB = beats(WIDTH, LANES);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nx;
    logic [CW-1:0]    cnt;
    logic             msb_q;
    logic             valid_q;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             fire;
    logic             at_last;
    logic             load;
`ifdef PISO_STREAM_PARITY_EN
    logic             par_q;
`endif

    assign ready_o = !fifo_full;
    assign push    = valid_i && ready_o;
    assign fire    = valid_q && ready_i;
    assign at_last = (cnt == CNT_LAST);
    assign load    = !fifo_empty &&
                     ((state == IDLE) || (fire && at_last));

    assign sreg_nx = (msb_q == ORDER_MSB) ? (sreg << LANES)
                                          : (sreg >> LANES);
    assign d_o     = (msb_q == ORDER_MSB) ? sreg[WIDTH-1 -: LANES]
                                          : sreg[LANES-1:0];
    assign valid_o = valid_q;
    assign last_o  = valid_q && at_last;
`ifdef PISO_STREAM_PARITY_EN
    assign par_o   = par_q;
`endif

    piso_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_i (rst_i),
        .push  (push),
        .wdata (d_i),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    // Load/shift FSM: a word loads whenever the shifter is free or
    // its last beat is leaving, so consecutive words have no bubble.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            msb_q   <= ORDER_LSB;
            valid_q <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (load) begin
            state   <= SHIFT;
            sreg    <= fifo_rdata;
            cnt     <= '0;
            msb_q   <= msb_first_i;
            valid_q <= 1'b1;
`ifdef PISO_STREAM_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
        end else if (state == SHIFT && fire) begin
            if (at_last) begin
                state   <= IDLE;
                sreg    <= '0;
                cnt     <= '0;
                valid_q <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
                par_q   <= 1'b0;
`endif
            end else begin
                sreg <= sreg_nx;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream (8/1/16 and 8/2/4 instances).
// Expected beats are queued at write time and popped as beats fire.
module tb_piso_stream;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] d_i;
    logic       valid_i;
    logic       msb_first_i;
    logic       ready_i;
    logic       ready_o;
    logic [0:0] d_o;
    logic       valid_o;
    logic       last_o;
    logic [4:0] level_o;

    logic [7:0] d_i2;
    logic       valid_i2;
    logic       ready_i2;
    logic       ready_o2;
    logic [1:0] d_o2;
    logic       valid_o2;
    logic       last_o2;
    logic [2:0] level_o2;

`ifdef PISO_STREAM_PARITY_EN
    logic       par_o;
    logic       par_o2;
`endif

    int total = 0;
    int bad   = 0;

    // {parity, last, bit}
    logic [2:0] sb_a[$];
    // {parity, last, beat[1:0]}
    logic [3:0] sb_b[$];

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(8), .LANES(1), .DEPTH(16)) dut_a (
        .clk         (clk),
        .rst_i       (rst_i),
        .d_i         (d_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .msb_first_i (msb_first_i),
        .d_o         (d_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .level_o     (level_o)
`ifdef PISO_STREAM_PARITY_EN
        ,
        .par_o       (par_o)
`endif
    );

    piso_stream #(.WIDTH(8), .LANES(2), .DEPTH(4)) dut_b (
        .clk         (clk),
        .rst_i       (rst_i),
        .d_i         (d_i2),
        .valid_i     (valid_i2),
        .ready_o     (ready_o2),
        .msb_first_i (msb_first_i),
        .d_o         (d_o2),
        .valid_o     (valid_o2),
        .ready_i     (ready_i2),
        .last_o      (last_o2),
        .level_o     (level_o2)
`ifdef PISO_STREAM_PARITY_EN
        ,
        .par_o       (par_o2)
`endif
    );

    task automatic model_a(input logic [7:0] w, input logic msb);
        for (int k = 0; k < 8; k++) begin
            sb_a.push_back({^w, (k == 7), msb ? w[7-k] : w[k]});
        end
    endtask

    task automatic model_b(input logic [7:0] w, input logic msb);
        logic [1:0] b;
        for (int k = 0; k < 4; k++) begin
            b = msb ? w[7-2*k -: 2] : w[2*k +: 2];
            sb_b.push_back({^w, (k == 3), b});
        end
    endtask

    task automatic test_reset();
        int n;
        int seen;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || last_o !== 1'b0 ||
            d_o !== 1'b0 || level_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_init: rdy=%b vld=%b last=%b d=%b lvl=%0d want 1 0 0 0 0",
                     ready_o, valid_o, last_o, d_o, level_o);
        end
`ifdef PISO_STREAM_PARITY_EN
        total++;
        if (par_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_par: par_o=%b want 0", par_o);
        end
`endif
        msb_first_i = 1'b1;
        ready_i = 1'b1;
        d_i = 8'hC1;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (valid_o && ready_i) n++;
        end
        @(negedge clk);
        total++;
        if (n !== 3 || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_prep: beats=%0d vld=%b want 3 1", n, valid_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (valid_o !== 1'b0 || last_o !== 1'b0 || d_o !== 1'b0 ||
            level_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_mid: vld=%b last=%b d=%b lvl=%0d want 0 0 0 0",
                     valid_o, last_o, d_o, level_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: ready_o=%b want 1", ready_o);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_noresidue: beats=%0d want 0", seen);
        end
    endtask

    task automatic test_stream(input logic [7:0] w, input logic msb,
                               input string nm);
        logic [2:0] e;
        ready_i = 1'b1;
        msb_first_i = msb;
        d_i = w;
        valid_i = 1'b1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_accept: ready_o=%b want 1", nm, ready_o);
        end
        model_a(w, msb);
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || level_o !== 5'd1) begin
            bad++;
            $display("FAIL %s_lat1: vld=%b lvl=%0d want 0 1", nm, valid_o, level_o);
        end
        @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || level_o !== 5'd0) begin
            bad++;
            $display("FAIL %s_lat2: vld=%b lvl=%0d want 1 0", nm, valid_o, level_o);
        end
        for (int c = 0; c < 30 && sb_a.size() != 0; c++) begin
            if (valid_o) begin
                e = sb_a.pop_front();
                total++;
                if (d_o !== e[0] || last_o !== e[1]) begin
                    bad++;
                    $display("FAIL %s_beat: d=%b last=%b want d=%b last=%b",
                             nm, d_o, last_o, e[0], e[1]);
                end
`ifdef PISO_STREAM_PARITY_EN
                total++;
                if (par_o !== e[2]) begin
                    bad++;
                    $display("FAIL %s_par: par_o=%b want %b", nm, par_o, e[2]);
                end
`endif
            end
            @(negedge clk);
        end
        total++;
        if (sb_a.size() != 0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: left=%0d vld=%b want 0 0", nm, sb_a.size(), valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] e;
        int n;
        int stall;
        bit pend;
        ready_i = 1'b1;
        msb_first_i = 1'b1;
        d_i = 8'hC1;
        valid_i = 1'b1;
        model_a(8'hC1, 1'b1);
        n = 0;
        stall = 0;
        pend = 0;
        for (int c = 0; c < 60 && sb_a.size() != 0; c++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (pend) begin
                ready_i = 1'b0;
                stall = 3;
                pend = 0;
            end
            if (stall > 0) begin
                total++;
                if (valid_o !== 1'b1 || d_o !== sb_a[0][0] || last_o !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_hold: vld=%b d=%b last=%b want 1 %b 0",
                             valid_o, d_o, last_o, sb_a[0][0]);
                end
                stall--;
            end else begin
                ready_i = 1'b1;
                if (valid_o) begin
                    e = sb_a.pop_front();
                    n++;
                    if (n == 4) pend = 1;
                    total++;
                    if (d_o !== e[0] || last_o !== e[1]) begin
                        bad++;
                        $display("FAIL bp_beat: d=%b last=%b want d=%b last=%b",
                                 d_o, last_o, e[0], e[1]);
                    end
                end
            end
        end
        @(negedge clk);
        total++;
        if (sb_a.size() != 0 || n != 8 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_end: left=%0d beats=%0d vld=%b want 0 8 0",
                     sb_a.size(), n, valid_o);
        end
    endtask

    task automatic test_full();
        logic [2:0] e;
        logic [7:0] w;
        int acc;
        int beats;
        int bubble;
        int first_rdy;
        ready_i = 1'b0;
        msb_first_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            d_i = w;
            valid_i = 1'b1;
            if (ready_o) begin
                model_a(w, 1'b1);
                acc++;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        total++;
        if (acc != 17 || level_o !== 5'd16 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_fill: acc=%0d lvl=%0d rdy=%b want 17 16 0",
                     acc, level_o, ready_o);
        end
        ready_i = 1'b1;
        beats = 0;
        bubble = 0;
        first_rdy = -1;
        for (int c = 0; c < 200 && sb_a.size() != 0; c++) begin
            if (c == 7) begin
                d_i = 8'hFF;
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            if (first_rdy < 0 && ready_o) first_rdy = c;
            if (valid_o) begin
                e = sb_a.pop_front();
                beats++;
                total++;
                if (d_o !== e[0] || last_o !== e[1]) begin
                    bad++;
                    $display("FAIL full_beat%0d: d=%b last=%b want d=%b last=%b",
                             beats, d_o, last_o, e[0], e[1]);
                end
            end else begin
                bubble++;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        total++;
        if (beats != 136 || bubble != 0) begin
            bad++;
            $display("FAIL full_drain: beats=%0d bubbles=%0d want 136 0", beats, bubble);
        end
        total++;
        if (first_rdy != 8) begin
            bad++;
            $display("FAIL full_ready: first ready cycle=%0d want 8", first_rdy);
        end
        total++;
        if (level_o !== 5'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_end: lvl=%0d vld=%b rdy=%b want 0 0 1",
                     level_o, valid_o, ready_o);
        end
    endtask

    task automatic test_multilane();
        logic [3:0] e;
        int n;
        int bubble;
        ready_i2 = 1'b1;
        msb_first_i = 1'b1;
        d_i2 = 8'hC1;
        valid_i2 = 1'b1;
        total++;
        if (ready_o2 !== 1'b1) begin
            bad++;
            $display("FAIL ml_accept0: ready_o=%b want 1", ready_o2);
        end
        model_b(8'hC1, 1'b1);
        @(negedge clk);
        d_i2 = 8'h5A;
        total++;
        if (ready_o2 !== 1'b1) begin
            bad++;
            $display("FAIL ml_accept1: ready_o=%b want 1", ready_o2);
        end
        model_b(8'h5A, 1'b1);
        @(negedge clk);
        valid_i2 = 1'b0;
        n = 0;
        bubble = 0;
        for (int c = 0; c < 30 && sb_b.size() != 0; c++) begin
            if (valid_o2) begin
                e = sb_b.pop_front();
                n++;
                total++;
                if (d_o2 !== e[1:0] || last_o2 !== e[2]) begin
                    bad++;
                    $display("FAIL ml_beat%0d: d=%b last=%b want d=%b last=%b",
                             n, d_o2, last_o2, e[1:0], e[2]);
                end
`ifdef PISO_STREAM_PARITY_EN
                total++;
                if (par_o2 !== e[3]) begin
                    bad++;
                    $display("FAIL ml_par%0d: par_o=%b want %b", n, par_o2, e[3]);
                end
`endif
            end else if (n > 0) begin
                bubble++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 8 || bubble != 0 || valid_o2 !== 1'b0) begin
            bad++;
            $display("FAIL ml_end: beats=%0d bubbles=%0d vld=%b want 8 0 0",
                     n, bubble, valid_o2);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        d_i = '0;
        valid_i = 1'b0;
        msb_first_i = 1'b1;
        ready_i = 1'b1;
        d_i2 = '0;
        valid_i2 = 1'b0;
        ready_i2 = 1'b1;
        test_reset();
        test_stream(8'hC1, 1'b1, "msb");
        test_stream(8'hC1, 1'b0, "lsb");
        test_backpressure();
        test_full();
        test_multilane();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
